// File: rtl/uc_port_master_if.sv
// Command/response handshake and microcontroller-side bus of uc_port_master.
// The uc_data pad tristate lives above this interface, so the bus is split into out/oe/in.
interface uc_port_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [14:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic [7:0]  uc_data_out;
    logic        uc_data_oe;
    logic [7:0]  uc_data_in;
    logic        uc_write;
    logic        uc_read;
    logic        set_addr_lo;
    logic        set_addr_hi;
    logic        strobe_addr;
    logic        uc_ack;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, uc_data_in, uc_ack,
        output cmd_ready, rsp_valid, rsp_data, uc_data_out, uc_data_oe,
               uc_write, uc_read, set_addr_lo, set_addr_hi, strobe_addr
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, uc_data_in, uc_ack,
        input  cmd_ready, rsp_valid, rsp_data, uc_data_out, uc_data_oe,
               uc_write, uc_read, set_addr_lo, set_addr_hi, strobe_addr
    );
endinterface

// File: rtl/uc_port_master.sv
// Master for a microcontroller SRAM port: loads the address counter in two byte strobes,
// performs ack-handshaked byte writes/reads and advances the address after each access.
module uc_port_master #(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned ACK_TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              reset_n,
    uc_port_master_if.master  bus,
    output logic [14:0]       cur_addr,
    output logic              busy,
    output logic              timeout_err,
    input  logic              err_clear
);
    typedef enum logic [3:0] {
        IDLE, LO_SETUP, LO_STROBE, LO_HOLD, HI_SETUP, HI_STROBE, HI_HOLD,
        REQ, RELEASE, INC_STROBE, INC_HOLD
    } state_t;

    typedef enum logic [1:0] {OP_SET = 2'b00, OP_WR = 2'b01, OP_RD = 2'b10, OP_RSV = 2'b11} op_t;

    localparam logic [3:0]  STB_LAST = 4'(STROBE_CYCLES - 1);
    localparam logic [15:0] TO_LAST  = 16'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [14:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [14:0] cur_addr_q, cur_addr_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        err_q, err_d;
    logic [3:0]  stb_cnt_q, stb_cnt_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        seen0_q, seen0_d;
    logic        ack_meta_q, ack_s_q;
    logic        timeout_fire;
    logic        ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            ack_meta_q <= bus.uc_ack;
            ack_s_q    <= ack_meta_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            op_q       <= OP_SET;
            addr_q     <= '0;
            wdata_q    <= '0;
            cur_addr_q <= '0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
            stb_cnt_q  <= '0;
            to_cnt_q   <= '0;
            seen0_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cur_addr_q <= cur_addr_d;
            rsp_data_q <= rsp_data_d;
            err_q      <= err_d;
            stb_cnt_q  <= stb_cnt_d;
            to_cnt_q   <= to_cnt_d;
            seen0_q    <= seen0_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cur_addr_d   = cur_addr_q;
        rsp_data_d   = rsp_data_q;
        stb_cnt_d    = stb_cnt_q;
        to_cnt_d     = to_cnt_q;
        seen0_d      = seen0_q;
        timeout_fire = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    op_d      = op_t'(bus.cmd_op);
                    addr_d    = bus.cmd_addr;
                    wdata_d   = bus.cmd_wdata;
                    stb_cnt_d = '0;
                    to_cnt_d  = '0;
                    seen0_d   = 1'b0;
                    unique case (op_t'(bus.cmd_op))
                        OP_SET:       state_d = LO_SETUP;
                        OP_WR, OP_RD: state_d = REQ;
                        default:      state_d = IDLE;
                    endcase
                end
            end
            LO_SETUP: state_d = LO_STROBE;
            LO_STROBE: begin
                if (stb_cnt_q == STB_LAST) begin
                    stb_cnt_d = '0;
                    state_d   = LO_HOLD;
                end else begin
                    stb_cnt_d = stb_cnt_q + 4'd1;
                end
            end
            LO_HOLD:  state_d = HI_SETUP;
            HI_SETUP: state_d = HI_STROBE;
            HI_STROBE: begin
                if (stb_cnt_q == STB_LAST) begin
                    stb_cnt_d = '0;
                    state_d   = HI_HOLD;
                end else begin
                    stb_cnt_d = stb_cnt_q + 4'd1;
                end
            end
            HI_HOLD: begin
                cur_addr_d = addr_q;
                state_d    = IDLE;
            end
            // An ack only counts once a low ack_s has been seen in this REQ, rejecting stale acks.
            REQ: begin
                if (ack_s_q && seen0_q) begin
                    if (op_q == OP_RD) rsp_data_d = bus.uc_data_in;
                    to_cnt_d = '0;
                    state_d  = RELEASE;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_fire = 1'b1;
                    state_d      = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                    if (!ack_s_q) seen0_d = 1'b1;
                end
            end
            RELEASE: begin
                if (!ack_s_q) begin
                    stb_cnt_d = '0;
                    state_d   = INC_STROBE;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_fire = 1'b1;
                    state_d      = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
            end
            INC_STROBE: begin
                if (stb_cnt_q == STB_LAST) begin
                    stb_cnt_d = '0;
                    state_d   = INC_HOLD;
                end else begin
                    stb_cnt_d = stb_cnt_q + 4'd1;
                end
            end
            INC_HOLD: begin
                cur_addr_d = cur_addr_q + 15'd1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A timeout wins over a simultaneous clear so the error is never lost.
    assign err_d = timeout_fire | (err_q & ~err_clear);

    always_comb begin
        bus.uc_data_out = '0;
        bus.uc_data_oe  = 1'b0;
        bus.uc_write    = 1'b0;
        bus.uc_read     = 1'b0;
        bus.set_addr_lo = 1'b0;
        bus.set_addr_hi = 1'b0;
        bus.strobe_addr = 1'b0;
        unique case (state_q)
            LO_SETUP, LO_STROBE, LO_HOLD: begin
                bus.uc_data_out = addr_q[7:0];
                bus.uc_data_oe  = 1'b1;
                bus.set_addr_lo = 1'b1;
                bus.strobe_addr = (state_q == LO_STROBE);
            end
            HI_SETUP, HI_STROBE, HI_HOLD: begin
                bus.uc_data_out = {1'b0, addr_q[14:8]};
                bus.uc_data_oe  = 1'b1;
                bus.set_addr_hi = 1'b1;
                bus.strobe_addr = (state_q == HI_STROBE);
            end
            REQ: begin
                if (op_q == OP_WR) begin
                    bus.uc_data_out = wdata_q;
                    bus.uc_data_oe  = 1'b1;
                    bus.uc_write    = 1'b1;
                end else begin
                    bus.uc_read = 1'b1;
                end
            end
            RELEASE: begin
                if (op_q == OP_WR) begin
                    bus.uc_data_out = wdata_q;
                    bus.uc_data_oe  = 1'b1;
                end
            end
            INC_STROBE: bus.strobe_addr = 1'b1;
            default: ;
        endcase
    end

    assign ready         = (state_q == IDLE);
    assign bus.cmd_ready = ready;
    assign busy          = ~ready;
    assign bus.rsp_valid = (state_q == INC_HOLD) && (op_q == OP_RD);
    assign bus.rsp_data  = rsp_data_q;
    assign cur_addr      = cur_addr_q;
    assign timeout_err   = err_q;
endmodule

// File: tb/tb_uc_port_master.sv
// Self-checking bench for uc_port_master: directed vector table, multi-cycle corner
// sequences, and randomized commands checked against a transaction-level address/data model.
module tb_uc_port_master;
    localparam int unsigned STB = 2;
    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        err_clear;
    logic [14:0] cur_addr;
    logic        busy;
    logic        timeout_err;

    uc_port_master_if bus();

    uc_port_master #(.STROBE_CYCLES(STB), .ACK_TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .cur_addr    (cur_addr),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clear   (err_clear)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Microcontroller model: acks ack_delay cycles after a request, drops ack once released.
    logic       ack_tie0  = 1'b0;
    logic       ack_force = 1'b0;
    int         ack_delay = 0;
    logic [7:0] rd_byte   = 8'h00;
    assign bus.uc_data_in = rd_byte;

    initial begin : ack_model
        int dly;
        dly = 0;
        bus.uc_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_force) begin
                bus.uc_ack = 1'b1;
                dly = 0;
            end else if (ack_tie0) begin
                bus.uc_ack = 1'b0;
                dly = 0;
            end else if (bus.uc_write || bus.uc_read) begin
                if (dly >= ack_delay) bus.uc_ack = 1'b1;
                else begin
                    bus.uc_ack = 1'b0;
                    dly++;
                end
            end else begin
                bus.uc_ack = 1'b0;
                dly = 0;
            end
        end
    end

    // Running totals; commands measure differences across their own window.
    int         tot_strobe = 0, tot_rsp = 0, tot_req = 0, tot_viol = 0, tot_acc = 0, tot_wr_pulse = 0;
    logic       prev_wr = 1'b0;
    logic [7:0] lo_seen = 8'h00, hi_seen = 8'h00;
    logic [8:0] wr_seen = 9'h000;

    always @(negedge clk) begin
        if (bus.strobe_addr) tot_strobe++;
        if (bus.rsp_valid) tot_rsp++;
        if (bus.uc_write || bus.uc_read) tot_req++;
        if ((bus.uc_write && bus.uc_read) || (bus.set_addr_lo && bus.set_addr_hi) ||
            (bus.uc_data_oe && bus.uc_read)) tot_viol++;
        if (bus.uc_write && !prev_wr) tot_wr_pulse++;
        prev_wr = bus.uc_write;
        if (bus.set_addr_lo && bus.strobe_addr) lo_seen = bus.uc_data_out;
        if (bus.set_addr_hi && bus.strobe_addr) hi_seen = bus.uc_data_out;
        if (bus.uc_write) wr_seen = {bus.uc_data_oe, bus.uc_data_out};
    end

    always @(posedge clk) if (bus.cmd_valid && bus.cmd_ready) tot_acc++;

    task automatic send(input logic [1:0] op, input logic [14:0] a, input logic [7:0] w);
        @(negedge clk);
        bus.cmd_op    = op;
        bus.cmd_addr  = a;
        bus.cmd_wdata = w;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_addr  = 15'($urandom);
        bus.cmd_wdata = 8'($urandom);
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (!bus.cmd_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.cmd_ready) begin
            n_checks++;
            n_err++;
            $display("FAIL ready_wait: cmd_ready=%0b after %0d cycles, required 1", bus.cmd_ready, cyc);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [14:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          dly;
        logic [14:0] exp_cur;
        logic [7:0]  exp_rsp;
        int          exp_rsp_n;
        int          exp_cycles;
        int          exp_strobe;
        int          exp_req;
    } vec_t;

    vec_t tbl [7];
    logic [7:0] qd [3] = '{8'h11, 8'h22, 8'h33};

    initial begin : main
        int cyc, s_stb, s_rsp, s_req, s_acc, s_wrp, acc, guard, d, exp_cyc, exp_stb, exp_rn;
        logic r;
        logic [1:0]  op;
        logic [14:0] a, model_addr;
        logic [7:0]  w, rb, model_rsp;

        tbl[0] = '{2'b00, 15'h1234, 8'h00, 8'h00, 0, 15'h1234, 8'h00, 0,  8, 4, 0};
        tbl[1] = '{2'b01, 15'h0000, 8'hA5, 8'h00, 5, 15'h1235, 8'h00, 0, 14, 2, 8};
        tbl[2] = '{2'b00, 15'h7FFF, 8'h00, 8'h00, 0, 15'h7FFF, 8'h00, 0,  8, 4, 0};
        tbl[3] = '{2'b10, 15'h0000, 8'h00, 8'h5A, 2, 15'h0000, 8'h5A, 1, 11, 2, 5};
        tbl[4] = '{2'b11, 15'h0555, 8'h00, 8'h00, 0, 15'h0000, 8'h5A, 0,  0, 0, 0};
        tbl[5] = '{2'b10, 15'h0000, 8'h00, 8'hC3, 0, 15'h0001, 8'hC3, 1,  9, 2, 3};
        tbl[6] = '{2'b01, 15'h0000, 8'h3C, 8'h00, 1, 15'h0002, 8'hC3, 0, 10, 2, 4};

        reset_n       = 1'b0;
        err_clear     = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready", bus.cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_cur_addr", cur_addr, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_oe", bus.uc_data_oe, 0);
        check("rst_data_out", bus.uc_data_out, 0);
        check("rst_strobes", {bus.uc_write, bus.uc_read, bus.set_addr_lo, bus.set_addr_hi,
                              bus.strobe_addr, bus.rsp_valid}, 0);

        for (int i = 0; i < 7; i++) begin
            s_stb = tot_strobe; s_rsp = tot_rsp; s_req = tot_req;
            ack_delay = tbl[i].dly;
            rd_byte   = tbl[i].rdata;
            send(tbl[i].op, tbl[i].addr, tbl[i].wdata);
            wait_idle(cyc);
            check($sformatf("v%0d_cycles", i), cyc, tbl[i].exp_cycles);
            check($sformatf("v%0d_cur_addr", i), cur_addr, tbl[i].exp_cur);
            check($sformatf("v%0d_rsp_data", i), bus.rsp_data, tbl[i].exp_rsp);
            check($sformatf("v%0d_rsp_pulses", i), tot_rsp - s_rsp, tbl[i].exp_rsp_n);
            check($sformatf("v%0d_strobe_cycles", i), tot_stb_diff(s_stb), tbl[i].exp_strobe);
            check($sformatf("v%0d_req_cycles", i), tot_req - s_req, tbl[i].exp_req);
            if (tbl[i].op == 2'b00) begin
                check($sformatf("v%0d_lo_byte", i), lo_seen, tbl[i].addr[7:0]);
                check($sformatf("v%0d_hi_byte", i), hi_seen, {1'b0, tbl[i].addr[14:8]});
            end
            if (tbl[i].op == 2'b01) check($sformatf("v%0d_wr_data", i), wr_seen, {1'b1, tbl[i].wdata});
        end

        // Write with no ack: request held for ACK_TIMEOUT cycles, error set, no increment.
        ack_tie0 = 1'b1;
        s_stb = tot_strobe; s_req = tot_req; s_rsp = tot_rsp;
        send(2'b01, 15'h0000, 8'h77);
        wait_idle(cyc);
        check("to_cycles", cyc, TMO);
        check("to_req_cycles", tot_req - s_req, TMO);
        check("to_err", timeout_err, 1);
        check("to_cur_addr", cur_addr, 15'h0002);
        check("to_no_strobe", tot_stb_diff(s_stb), 0);
        check("to_no_rsp", tot_rsp - s_rsp, 0);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        @(negedge clk);
        check("to_err_cleared", timeout_err, 0);

        // err_clear held through a timeout: the timeout cycle must still set the flag.
        err_clear = 1'b1;
        send(2'b10, 15'h0000, 8'h00);
        wait_idle(cyc);
        check("to_clr_same_cycle", timeout_err, 1);
        err_clear = 1'b0;
        @(negedge clk);
        check("to_err_sticky", timeout_err, 1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        ack_tie0 = 1'b0;
        @(negedge clk);
        check("to_err_cleared2", timeout_err, 0);

        // Stale ack: ack already high when the write starts must not complete it.
        ack_force = 1'b1;
        ack_delay = 3;
        repeat (3) @(negedge clk);
        s_req = tot_req;
        send(2'b01, 15'h0000, 8'h99);
        repeat (5) @(negedge clk);
        check("stale_hold_write", bus.uc_write, 1);
        #2 ack_force = 1'b0;
        wait_idle(cyc);
        check("stale_req_cycles", tot_req - s_req, 12);
        check("stale_cur_addr", cur_addr, 15'h0003);
        check("stale_no_err", timeout_err, 0);
        check("stale_wr_data", wr_seen, 9'h199);

        // Three writes queued behind a continuously high cmd_valid.
        ack_delay = 1;
        s_acc = tot_acc; s_wrp = tot_wr_pulse; s_stb = tot_strobe;
        @(negedge clk);
        bus.cmd_op    = 2'b01;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = qd[0];
        bus.cmd_valid = 1'b1;
        acc = 0;
        guard = 0;
        while (acc < 3 && guard < 300) begin
            r = bus.cmd_ready;
            @(negedge clk);
            guard++;
            if (r) begin
                acc++;
                if (acc < 3) bus.cmd_wdata = qd[acc];
                else bus.cmd_valid = 1'b0;
            end
        end
        bus.cmd_valid = 1'b0;
        wait_idle(cyc);
        check("q_acceptances", tot_acc - s_acc, 3);
        check("q_write_pulses", tot_wr_pulse - s_wrp, 3);
        check("q_strobe_cycles", tot_stb_diff(s_stb), 3 * STB);
        check("q_cur_addr", cur_addr, 15'h0006);
        check("q_last_data", wr_seen, 9'h133);

        // Randomized commands against a transaction-level model.
        model_addr = 15'h0006;
        model_rsp  = 8'hC3;
        for (int k = 0; k < 40; k++) begin
            op = 2'($urandom_range(0, 3));
            a  = 15'($urandom);
            w  = 8'($urandom);
            rb = 8'($urandom);
            d  = int'($urandom_range(0, 6));
            exp_rn = 0;
            case (op)
                2'b00: begin
                    model_addr = a;
                    exp_cyc = 4 + 2 * STB;
                    exp_stb = 2 * STB;
                end
                2'b01, 2'b10: begin
                    model_addr = 15'((int'(model_addr) + 1) % 32768);
                    // ack delay + 2 sync flops + 1 decision, 3 to see ack drop, increment strobe + hold
                    exp_cyc = d + 3 + 3 + STB + 1;
                    exp_stb = STB;
                    if (op == 2'b10) begin
                        model_rsp = rb;
                        exp_rn = 1;
                    end
                end
                default: begin
                    exp_cyc = 0;
                    exp_stb = 0;
                end
            endcase
            s_stb = tot_strobe; s_rsp = tot_rsp;
            ack_delay = d;
            rd_byte   = rb;
            send(op, a, w);
            wait_idle(cyc);
            check($sformatf("r%0d_cycles", k), cyc, exp_cyc);
            check($sformatf("r%0d_cur_addr", k), cur_addr, model_addr);
            check($sformatf("r%0d_rsp_data", k), bus.rsp_data, model_rsp);
            check($sformatf("r%0d_rsp_pulses", k), tot_rsp - s_rsp, exp_rn);
            check($sformatf("r%0d_strobe_cycles", k), tot_stb_diff(s_stb), exp_stb);
        end

        // Asynchronous reset while a read waits for ack.
        ack_tie0 = 1'b1;
        s_rsp = tot_rsp;
        send(2'b10, 15'h0000, 8'h00);
        repeat (3) @(negedge clk);
        check("rstmid_read_active", bus.uc_read, 1);
        #2 reset_n = 1'b0;
        #1;
        check("rstmid_read_dropped", bus.uc_read, 0);
        check("rstmid_cur_addr", cur_addr, 0);
        check("rstmid_ready", bus.cmd_ready, 1);
        @(negedge clk);
        reset_n  = 1'b1;
        ack_tie0 = 1'b0;
        @(negedge clk);
        check("rstmid_ready_after", bus.cmd_ready, 1);
        check("rstmid_rsp_data", bus.rsp_data, 0);
        check("rstmid_no_rsp", tot_rsp - s_rsp, 0);
        ack_delay = 0;
        send(2'b01, 15'h0000, 8'h5C);
        wait_idle(cyc);
        check("rstmid_post_write_addr", cur_addr, 15'h0001);

        check("no_overlap", tot_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    function automatic int tot_stb_diff(input int start);
        return tot_strobe - start;
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uc_port_master.md
UC_PORT_MASTER -- requirements
Module: uc_port_master

Interface
REQ-001 Parameter STROBE_CYCLES, default 2, width in clk cycles of every strobe_addr high pulse (legal 1..15).
REQ-002 Parameter ACK_TIMEOUT, default 1023, max clk cycles spent waiting for any single uc_ack edge (legal 1..65535).
REQ-003 Port: clk  in  1  single clock; all logic on its rising edge.
REQ-004 Port: reset_n  in  1  asynchronous active-low reset.
REQ-005 Ports: cmd_valid in 1, cmd_ready out 1 -- command handshake; transfer when both high on a rising clk edge.
REQ-006 Ports: cmd_op in 2 (00 set address, 01 write byte, 10 read byte, 11 reserved); cmd_addr in 15; cmd_wdata in 8.
REQ-007 Ports: rsp_valid out 1 (one-cycle pulse), rsp_data out 8 (read byte, held until next read completes).
REQ-008 Ports: uc_data_out out 8, uc_data_oe out 1, uc_data_in in 8 -- split form of the bidirectional uc_data bus; the pad tristate sits in the top level.
REQ-009 Ports: uc_write, uc_read, set_addr_lo, set_addr_hi, strobe_addr out 1 each; uc_ack in 1 (asynchronous to clk).
REQ-010 Ports: cur_addr out 15 (shadow of the SRAM-side address counter), busy out 1, timeout_err out 1, err_clear in 1.

Function
REQ-011 The block SHALL pass uc_ack through a 2-flop synchronizer; all ack decisions use the synchronized value ack_s.
REQ-012 cmd_ready SHALL equal 1 only in IDLE; busy SHALL equal ~cmd_ready.
REQ-013 States: IDLE, LO_SETUP, LO_STROBE, LO_HOLD, HI_SETUP, HI_STROBE, HI_HOLD, REQ, RELEASE, INC_STROBE, INC_HOLD.
REQ-014 Set address (op 00) SHALL run IDLE->LO_SETUP(1 cycle)->LO_STROBE(STROBE_CYCLES)->LO_HOLD(1)->HI_SETUP(1)->HI_STROBE(STROBE_CYCLES)->HI_HOLD(1)->IDLE, total 4+2*STROBE_CYCLES cycles.
REQ-015 During LO_*: uc_data_out=cmd_addr[7:0], uc_data_oe=1, set_addr_lo=1; during HI_*: uc_data_out={1'b0,cmd_addr[14:8]}, uc_data_oe=1, set_addr_hi=1; strobe_addr=1 only in *_STROBE.
REQ-016 cur_addr SHALL load cmd_addr on the HI_HOLD->IDLE transition.
REQ-017 Write (op 01): REQ drives uc_data_out=cmd_wdata, uc_data_oe=1, uc_write=1 until ack_s=1; RELEASE keeps data, uc_write=0, until ack_s=0.
REQ-018 Read (op 10): REQ drives uc_read=1, uc_data_oe=0 until ack_s=1; rsp_data SHALL capture uc_data_in on the cycle ack_s is first seen 1; RELEASE drops uc_read until ack_s=0.
REQ-019 After RELEASE: INC_STROBE(STROBE_CYCLES, strobe_addr=1, both set_addr_* = 0) then INC_HOLD(1) then IDLE; cur_addr SHALL increment by 1 modulo 2^15 (0x7FFF->0x0000) on leaving INC_HOLD.
REQ-020 rsp_valid SHALL pulse for one cycle on the INC_HOLD->IDLE transition of a read only.
REQ-021 Command fields SHALL be registered at acceptance; later changes on cmd_* have no effect until the next acceptance.
REQ-022 uc_write and uc_read SHALL never be high together; set_addr_lo/hi SHALL never be high together; uc_data_oe=0 whenever uc_read=1.
REQ-023 Timeout: a counter reset on entry to REQ and RELEASE; reaching ACK_TIMEOUT SHALL drop all strobes, set timeout_err, skip increment and rsp_valid, return to IDLE.
REQ-024 timeout_err SHALL be sticky; err_clear=1 clears it; a timeout and err_clear in the same cycle leaves timeout_err=1.
REQ-025 Reserved op 11 SHALL be accepted and complete in one cycle with no bus activity.
REQ-026 If ack_s is already 1 on entry to REQ, the block SHALL stay in REQ until ack_s=1 again after first seeing 0 (stale-ack guard).

Reset
REQ-027 reset_n=0 SHALL immediately force IDLE, all bus strobes/uc_data_oe/rsp_valid/timeout_err=0, uc_data_out=0, rsp_data=0, cur_addr=0, synchronizer=0.
REQ-028 Reset mid-transaction SHALL abandon it without completing the handshake or incrementing cur_addr.

Verification
REQ-029 Set address 0x1234, STROBE_CYCLES=2 -> lo byte 0x34 with set_addr_lo, hi byte 0x12 with set_addr_hi, two 2-cycle strobes, cmd_ready back after 8 cycles, cur_addr=0x1234.
REQ-030 Write 0xA5, model acks 5 cycles after uc_write -> uc_write held until ack_s, released, one increment strobe, cur_addr 0x1234->0x1235, no rsp_valid.
REQ-031 Set 0x7FFF then read, model returns 0x5A -> rsp_data=0x5A, one rsp_valid pulse, cur_addr=0x0000.
REQ-032 Write with uc_ack tied 0, ACK_TIMEOUT=16 -> uc_write drops after 16 cycles, timeout_err=1, cur_addr unchanged; err_clear pulse -> 0.
REQ-033 reset_n low during REQ of a read -> uc_read=0 asynchronously, cur_addr=0, cmd_ready=1 after release.
REQ-034 cmd_valid held high with 3 queued writes -> exactly 3 acceptances, 3 increments, uc_write/uc_read never overlapping.
